users_count_uart_tx: RTL

- Downstream stage of the subscriber-detect FSM.
- Consumes that FSM's one-cycle detect pulse `y` and its 10-bit `users_count`.
- On each pulse, snapshots the count and sends it out LSB-first as a framed serial word: start bit, data, optional parity, stop bit.
- One-entry pending buffer absorbs a pulse that arrives mid-frame. Further pulses are dropped and flagged.

---
 rtl/users_count_uart_tx_pkg.sv | 30 +++
 rtl/users_count_uart_tx_if.sv | 28 ++
 rtl/users_count_uart_tx_bit_timer.sv | 34 +++
 rtl/users_count_uart_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/users_count_uart_tx_pkg.sv
// Purpose : shared constants and state encoding for the users_count serial transmitter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_W default, FSM state encoding, FRAME_BITS (bits per frame, including
//           start and stop). Optional macro USERS_COUNT_UART_PARITY_EN adds a parity bit.
package users_count_pkg;

  localparam int DATA_W = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

`ifdef USERS_COUNT_UART_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif

endpackage

// File: rtl/users_count_uart_tx_if.sv
// Purpose : event/count input and serial/status outputs of the users_count transmitter.
// Latency : n/a (wires only).
// Backpressure: none; evt is a fire-and-forget pulse, excess pulses are counted as drops.
// Ports   : evt, count_in (upstream -> tx); tx, busy, pend_valid, frame_done, overrun,
//           drop_cnt (tx -> observers). master = upstream side, slave = transmitter.
interface users_count_uart_tx_if #(
  parameter int DATA_W = 10,
  parameter int DROP_W = 4
);
  logic              evt;
  logic [DATA_W-1:0] count_in;
  logic              tx;
  logic              busy;
  logic              pend_valid;
  logic              frame_done;
  logic              overrun;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output evt, count_in,
    input  tx, busy, pend_valid, frame_done, overrun, drop_cnt
  );

  modport slave (
    input  evt, count_in,
    output tx, busy, pend_valid, frame_done, overrun, drop_cnt
  );
endinterface

// File: rtl/users_count_uart_tx_bit_timer.sv
// Purpose : baud counter holding each serial bit for CLKS_PER_BIT cycles.
// Latency : bit_end asserts on the last cycle of every bit period while run is high.
// Backpressure: none.
// Ports   : clk, rst (async active-low), run (frame in progress), restart (new frame
//           begins next cycle), bit_end (last cycle of bit), bit_pre_end (second-to-last).
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;

  assign bit_end     = run && (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign bit_pre_end = run && (cnt_q == CW'(CLKS_PER_BIT - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || !run || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/users_count_uart_tx.sv
// Purpose : serialises users_count snapshots taken on each detect pulse (start, LSB-first
//           data, optional parity, stop). Macro USERS_COUNT_UART_PARITY_EN adds parity.
// Latency : tx goes low on the edge that samples evt in IDLE; frame = FRAME_BITS*CLKS_PER_BIT.
// Backpressure: one-entry pending buffer; further evts while it is full are dropped and counted.
// Ports   : clk, rst (async active-low), bus (slave modport of users_count_uart_tx_if).
module users_count_uart_tx
  import users_count_pkg::*;
#(
  parameter int DATA_W       = users_count_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int DROP_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  users_count_uart_tx_if.slave bus
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  state_t            state_q, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] pend_dat_q, pend_dat_n;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_n;
  logic [DROP_W-1:0] drop_q, drop_n;
  logic              par_q, par_n;
  logic              pend_vld_q, pend_vld_n;
  logic              tx_q, tx_n;
  logic              ovr_q, ovr_n;
  logic              fd_q, fd_n;

  logic              start_load;
  logic [DATA_W-1:0] load_word;
  logic              drop_evt;
  logic              frame_end;
  logic              run;
  logic              bit_end;
  logic              bit_pre_end;

  assign run       = (state_q != IDLE);
  assign frame_end = (state_q == STOP) && bit_end;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .restart     (start_load),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    bit_cnt_n  = bit_cnt_q;
    par_n      = par_q;
    pend_vld_n = pend_vld_q;
    pend_dat_n = pend_dat_q;
    ovr_n      = ovr_q;
    drop_n     = drop_q;
    start_load = 1'b0;
    load_word  = bus.count_in;
    drop_evt   = 1'b0;
    tx_n       = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.evt) start_load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef USERS_COUNT_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            shift_n   = shift_q >> 1;
            bit_cnt_n = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (pend_vld_q) begin
            // Pending word goes out next; a coincident evt refills the buffer
            // rather than being dropped, since the slot frees this very cycle.
            start_load = 1'b1;
            load_word  = pend_dat_q;
            pend_vld_n = bus.evt;
            if (bus.evt) pend_dat_n = bus.count_in;
          end else if (bus.evt) begin
            start_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Mid-frame events (the frame-end boundary is resolved above).
    if (bus.evt && run && !frame_end) begin
      if (!pend_vld_q) begin
        pend_vld_n = 1'b1;
        pend_dat_n = bus.count_in;
      end else begin
        drop_evt = 1'b1;
      end
    end

    if (start_load) begin
      state_n   = START;
      shift_n   = load_word;
      par_n     = ^load_word;
      bit_cnt_n = '0;
    end

    if (drop_evt) begin
      ovr_n = 1'b1;
      if (drop_q != {DROP_W{1'b1}}) drop_n = drop_q + 1'b1;
    end

    // tx is registered, so it is derived from the state being entered.
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase

    // Registered strobe lands on the final STOP cycle.
    fd_n = (state_q == STOP) && bit_pre_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      tx_q       <= 1'b1;
      ovr_q      <= 1'b0;
      drop_q     <= '0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_n;
      shift_q    <= shift_n;
      bit_cnt_q  <= bit_cnt_n;
      par_q      <= par_n;
      pend_vld_q <= pend_vld_n;
      pend_dat_q <= pend_dat_n;
      tx_q       <= tx_n;
      ovr_q      <= ovr_n;
      drop_q     <= drop_n;
      fd_q       <= fd_n;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = run;
  assign bus.pend_valid = pend_vld_q;
  assign bus.frame_done = fd_q;
  assign bus.overrun    = ovr_q;
  assign bus.drop_cnt   = drop_q;

endmodule
